// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state encoding and default sizing for the note sequencer
package note_seq_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int TICK_DIV_DEF = 100000;
  localparam int NOTE_TICKS_DEF = 25;
  typedef enum logic [2:0] {
    IDLE, REC_CLR, RECORD, REC_FLUSH, PLAY_RST, PLAY_FETCH, PLAY_CHECK, PLAY_HOLD
  } state_t;
endpackage

// File: rtl/note_seq_tick.sv
// note_seq_tick: free-running divider emitting a one-cycle tick every TICK_DIV enabled cycles
module note_seq_tick
  import note_seq_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [TW-1:0] cnt;
  assign tick = en && cnt == TW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/note_seq_ctrl.sv
// note_seq_ctrl: record/playback sequencer driving the note memory; NOTE_SEQ_LOOP_EN enables looped playback
module note_seq_ctrl
  import note_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int NOTE_TICKS = NOTE_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rec_start,
  input  logic                  play_start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] key_note,
  input  logic                  key_valid,
  output logic                  mem_rst_n,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic                  mem_read_rst,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_output_ready,
  output logic [DATA_WIDTH-1:0] play_note,
  output logic                  play_valid,
  output logic                  busy,
  output logic [2:0]            state_out
);
  localparam int HW = $clog2(NOTE_TICKS + 1);
  state_t state, nxt;
  logic [HW-1:0] hold_cnt;
  logic tick, stop_play, hold_done, loop_again, valid_d;
  logic [DATA_WIDTH-1:0] note_d;
  note_seq_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state == PLAY_CHECK),
    .en  (state == PLAY_HOLD),
    .tick(tick)
  );
  assign stop_play = stop && state >= PLAY_RST;
  assign hold_done = tick && hold_cnt == HW'(NOTE_TICKS - 1);
  assign busy = state != IDLE;
  assign state_out = state;
`ifdef NOTE_SEQ_LOOP_EN
  // Only rewind when this pass produced something, so an empty memory never spins
  logic played;
  always_ff @(posedge clk or posedge rst)
    if (rst) played <= 1'b0;
    else if (state == PLAY_RST) played <= 1'b0;
    else if (state == PLAY_CHECK && mem_output_ready) played <= 1'b1;
  assign loop_again = played;
`else
  assign loop_again = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = stop ? IDLE : rec_start ? REC_CLR : play_start ? PLAY_RST : IDLE;
      REC_CLR:    nxt = RECORD;
      RECORD:     nxt = stop ? REC_FLUSH : RECORD;
      REC_FLUSH:  nxt = IDLE;
      PLAY_RST:   nxt = stop ? IDLE : PLAY_FETCH;
      PLAY_FETCH: nxt = stop ? IDLE : PLAY_CHECK;
      PLAY_CHECK: nxt = stop ? IDLE : mem_output_ready ? PLAY_HOLD : loop_again ? PLAY_RST : IDLE;
      PLAY_HOLD:  nxt = stop ? IDLE : hold_done ? PLAY_FETCH : PLAY_HOLD;
      default:    nxt = IDLE;
    endcase
  end
  // The played note only changes at a fetch result or an abort; across a loop wrap it is held
  always_comb begin
    note_d = stop_play ? '0 : state != PLAY_CHECK ? play_note :
             mem_output_ready ? mem_data_out : loop_again ? play_note : '0;
    valid_d = stop_play ? 1'b0 : state != PLAY_CHECK ? play_valid : mem_output_ready | loop_again;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      mem_rst_n    <= 1'b1;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_read_rst <= 1'b0;
      mem_data_in  <= '0;
      play_note    <= '0;
      play_valid   <= 1'b0;
    end else begin
      state        <= nxt;
      hold_cnt     <= state == PLAY_CHECK ? '0 : (state == PLAY_HOLD && tick) ? hold_cnt + 1'b1 : hold_cnt;
      mem_rst_n    <= nxt != REC_CLR;
      mem_write_en <= nxt == RECORD && key_valid;
      mem_read_en  <= nxt == PLAY_FETCH;
      mem_read_rst <= nxt == PLAY_RST;
      mem_data_in  <= nxt == RECORD ? key_note : '0;
      play_note    <= note_d;
      play_valid   <= valid_d;
    end
endmodule

// File: tb/tb_note_seq_ctrl.sv
// tb_note_seq_ctrl: directed and randomized record/playback checks against a behavioural note memory and timeline model
module tb_note_seq_ctrl;
  localparam int DW = 8, TD = 4, NT = 2, PER = NT * TD + 2;
`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, key_valid = 1'b0;
  logic [DW-1:0] key_note = '0;
  logic mem_rst_n, mem_write_en, mem_read_en, mem_read_rst, play_valid, busy;
  logic [DW-1:0] mem_data_in, play_note;
  logic [DW-1:0] mem_data_out = '0;
  logic mem_output_ready = 1'b0;
  logic [2:0] state_out;
  int errors = 0, checks = 0;
  int we_cnt, rstn_cnt, rd_cnt, pv_cnt;
  logic [DW-1:0] kv[$], exp_q[$];
  int kd[$];

  always #5 clk = ~clk;

  note_seq_ctrl #(.DATA_WIDTH(DW), .TICK_DIV(TD), .NOTE_TICKS(NT)) dut (
    .clk(clk), .rst(rst), .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .key_note(key_note), .key_valid(key_valid), .mem_rst_n(mem_rst_n),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_read_rst(mem_read_rst),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_output_ready(mem_output_ready),
    .play_note(play_note), .play_valid(play_valid), .busy(busy), .state_out(state_out)
  );

  // Note memory: holds a pending note (0 after clear), commits it when a different note arrives or writing stops
  logic [DW-1:0] mem[$];
  logic [DW-1:0] pend = '0;
  logic prev_we = 1'b0;
  int rp = 0;
  always @(posedge clk) begin
    if (!mem_rst_n) begin
      mem.delete();
      pend = '0;
      prev_we = 1'b0;
    end else begin
      if (mem_write_en && mem_data_in != pend) begin
        mem.push_back(pend);
        pend = mem_data_in;
      end
      if (prev_we && !mem_write_en) mem.push_back(pend);
      prev_we = mem_write_en;
    end
    if (mem_read_rst) rp = 0;
    else if (mem_read_en) begin
      if (rp < mem.size()) begin
        mem_data_out <= mem[rp];
        mem_output_ready <= 1'b1;
        rp++;
      end else mem_output_ready <= 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    we_cnt += int'(mem_write_en);
    rstn_cnt += int'(!mem_rst_n);
    rd_cnt += int'(mem_read_en);
    pv_cnt += int'(play_valid);
  endtask

  task automatic clr_cnt();
    we_cnt = 0;
    rstn_cnt = 0;
    rd_cnt = 0;
    pv_cnt = 0;
  endtask

  task automatic build_exp();
    exp_q.delete();
    if (kv.size() > 0) begin
      exp_q.push_back('0);
      foreach (kv[i]) if (kv[i] != exp_q[$]) exp_q.push_back(kv[i]);
    end
  endtask

  // Expected outputs t cycles after play_start was sampled, from the per-entry timing rules
  task automatic exp_at(input int t, output logic [2:0] st, output logic v, output logic [DW-1:0] nt);
    int n, per, u, r;
    n = exp_q.size();
    per = PER * n + 3;
    st = 3'd0;
    v = 1'b0;
    nt = '0;
    if (n == 0) st = t < 3 ? 3'(4 + t) : 3'd0;
    else begin
      u = LOOP ? t % per : t;
      if (u < 3) begin
        st = 3'(4 + u);
        v = t >= 3;
        nt = t >= 3 ? exp_q[n-1] : '0;
      end else if (u < per) begin
        r = (u - 3) % PER;
        st = r < PER - 2 ? 3'd7 : r == PER - 2 ? 3'd5 : 3'd6;
        v = 1'b1;
        nt = exp_q[(u-3)/PER];
      end
    end
  endtask

  task automatic play_run(input int len, input string tag);
    logic [2:0] st;
    logic v;
    logic [DW-1:0] nt;
    play_start = 1'b1;
    cyc();
    play_start = 1'b0;
    for (int t = 0; t < len; t++) begin
      if (t > 0) cyc();
      exp_at(t, st, v, nt);
      chk({tag, ".state"}, 32'(state_out), 32'(st));
      chk({tag, ".valid"}, 32'(play_valid), 32'(v));
      chk({tag, ".note"}, 32'(play_note), 32'(nt));
      chk({tag, ".busy"}, 32'(busy), 32'(st != 3'd0));
      chk({tag, ".rd_en"}, 32'(mem_read_en), 32'(st == 3'd5));
      chk({tag, ".rd_rst"}, 32'(mem_read_rst), 32'(st == 3'd4));
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk({tag, ".stop_state"}, 32'(state_out), 32'd0);
    chk({tag, ".stop_valid"}, 32'(play_valid), 32'd0);
    chk({tag, ".stop_note"}, 32'(play_note), 32'd0);
    chk({tag, ".stop_rd"}, 32'(mem_read_en), 32'd0);
  endtask

  function automatic int full_len();
    return (LOOP && exp_q.size() > 0) ? 2 * (PER * exp_q.size() + 3) + 4 : PER * exp_q.size() + 5;
  endfunction

  task automatic do_record(input string tag);
    int total;
    total = 0;
    build_exp();
    clr_cnt();
    rec_start = 1'b1;
    cyc();
    rec_start = 1'b0;
    chk({tag, ".clr_state"}, 32'(state_out), 32'd1);
    chk({tag, ".clr_rstn"}, 32'(mem_rst_n), 32'd0);
    cyc();
    chk({tag, ".rec_state"}, 32'(state_out), 32'd2);
    foreach (kv[i]) begin
      key_note = kv[i];
      key_valid = 1'b1;
      total += kd[i];
      repeat (kd[i]) cyc();
    end
    key_valid = 1'b0;
    key_note = '0;
    cyc();
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk({tag, ".flush_state"}, 32'(state_out), 32'd3);
    chk({tag, ".flush_we"}, 32'(mem_write_en), 32'd0);
    cyc();
    chk({tag, ".idle_state"}, 32'(state_out), 32'd0);
    chk({tag, ".we_cycles"}, 32'(we_cnt), 32'(total));
    chk({tag, ".rstn_cycles"}, 32'(rstn_cnt), 32'd1);
    chk({tag, ".mem_size"}, 32'(mem.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) chk({tag, ".mem_entry"}, 32'(mem[i]), 32'(exp_q[i]));
  endtask

  initial begin
    clr_cnt();
    repeat (3) cyc();
    chk("rst.state", 32'(state_out), 32'd0);
    chk("rst.rstn", 32'(mem_rst_n), 32'd1);
    chk("rst.we", 32'(mem_write_en), 32'd0);
    chk("rst.rd", 32'(mem_read_en), 32'd0);
    chk("rst.rdrst", 32'(mem_read_rst), 32'd0);
    chk("rst.din", 32'(mem_data_in), 32'd0);
    chk("rst.valid", 32'(play_valid), 32'd0);
    chk("rst.note", 32'(play_note), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc();
    stop = 1'b1;
    play_start = 1'b1;
    cyc();
    stop = 1'b0;
    play_start = 1'b0;
    chk("stop_wins.state", 32'(state_out), 32'd0);
    chk("stop_wins.rdrst", 32'(mem_read_rst), 32'd0);
    kv = '{8'd5, 8'd7};
    kd = '{10, 6};
    do_record("rec57");
    play_run(full_len(), "play57");
    play_run(16, "stop_hold");
    clr_cnt();
    repeat (20) cyc();
    chk("stop_hold.no_reads", 32'(rd_cnt), 32'd0);
    chk("stop_hold.no_valid", 32'(pv_cnt), 32'd0);
    repeat (2) begin
      kv.delete();
      kd.delete();
      repeat ($urandom_range(2, 5)) begin
        kv.push_back(DW'($urandom_range(1, 15)));
        kd.push_back(int'($urandom_range(1, 3)));
      end
      do_record("rec_rand");
      play_run(full_len(), "play_rand");
    end
    kv.delete();
    kd.delete();
    do_record("rec_empty");
    clr_cnt();
    play_run(full_len(), "play_empty");
    chk("play_empty.never_valid", 32'(pv_cnt), 32'd0);
    rec_start = 1'b1;
    play_start = 1'b1;
    cyc();
    rec_start = 1'b0;
    play_start = 1'b0;
    chk("rec_wins.state", 32'(state_out), 32'd1);
    cyc();
    chk("rec_wins.record", 32'(state_out), 32'd2);
    key_note = 8'd9;
    key_valid = 1'b1;
    cyc();
    chk("midrec.we", 32'(mem_write_en), 32'd1);
    chk("midrec.din", 32'(mem_data_in), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.state", 32'(state_out), 32'd0);
    chk("async_rst.we", 32'(mem_write_en), 32'd0);
    chk("async_rst.din", 32'(mem_data_in), 32'd0);
    chk("async_rst.rstn", 32'(mem_rst_n), 32'd1);
    chk("async_rst.busy", 32'(busy), 32'd0);
    cyc();
    rst = 1'b0;
    key_valid = 1'b0;
    key_note = '0;
    cyc();
    chk("after_rst.state", 32'(state_out), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
